// File: rtl/ped_request_ctrl.sv
// ped_request_ctrl: pedestrian push-button request controller.
// Synchronizes and debounces the raw button, turns debounced presses into
// shorten-green requests toward the light controller, and enforces a
// cooldown after each served request.
// Optional feature: define PED_REQ_BLINK_EN to blink wait_led while PENDING.
module ped_request_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int COOLDOWN_S      = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_n,
  input  logic [1:0] light_state,
  input  logic       sec_tick,
  input  logic       req_ack,
  output logic       req_valid,
  output logic       wait_led,
  output logic [1:0] fsm_state,
  output logic [7:0] press_count
);

  localparam logic [1:0] ST_IDLE     = 2'b00;
  localparam logic [1:0] ST_PENDING  = 2'b01;
  localparam logic [1:0] ST_GRANTED  = 2'b10;
  localparam logic [1:0] ST_COOLDOWN = 2'b11;

  localparam logic [1:0] LS_GREEN = 2'b00;
  localparam logic [1:0] LS_RED   = 2'b10;

  // Debounce counter only has to reach DEBOUNCE_CYCLES-1.
  localparam int          DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [4:0]  CD_LAST = 5'(COOLDOWN_S - 1);

  logic            sync1_r;
  logic            sync2_r;
  logic            deb_r;
  logic            deb_prev_r;
  logic [DB_W-1:0] db_cnt_r;
  logic            press_s;
  logic [1:0]      state_r;
  logic [1:0]      state_nxt_s;
  logic [4:0]      sec_cnt_r;
  logic [7:0]      press_count_r;
  logic            count_en_s;

  // Two-flop synchronizer and consecutive-cycle debounce of the button level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r    <= 1'b1;
      sync2_r    <= 1'b1;
      deb_r      <= 1'b1;
      deb_prev_r <= 1'b1;
      db_cnt_r   <= {DB_W{1'b0}};
    end else begin
      sync1_r    <= btn_n;
      sync2_r    <= sync1_r;
      deb_prev_r <= deb_r;
      if (sync2_r != deb_r) begin
        if (db_cnt_r == DB_LAST) begin
          deb_r    <= sync2_r;
          db_cnt_r <= {DB_W{1'b0}};
        end else begin
          db_cnt_r <= db_cnt_r + DB_W'(1);
        end
      end else begin
        db_cnt_r <= {DB_W{1'b0}};
      end
    end
  end

  // A press is the single cycle after the debounced level falls; releases are silent.
  assign press_s = deb_prev_r & ~deb_r;

  // Request is offered only while pending and the light is green.
  assign req_valid = (state_r == ST_PENDING) && (light_state == LS_GREEN);

  // Press events are counted in every state except COOLDOWN.
  assign count_en_s = press_s && (state_r != ST_COOLDOWN);

  // Next-state logic; handshake is judged on this cycle's req_valid.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (press_s) begin
          state_nxt_s = ST_PENDING;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PENDING: begin
        if (req_valid && req_ack) begin
          state_nxt_s = ST_GRANTED;
        end else if (light_state == LS_RED) begin
          state_nxt_s = ST_COOLDOWN;
        end else begin
          state_nxt_s = ST_PENDING;
        end
      end
      ST_GRANTED: begin
        if (light_state == LS_RED) begin
          state_nxt_s = ST_COOLDOWN;
        end else begin
          state_nxt_s = ST_GRANTED;
        end
      end
      ST_COOLDOWN: begin
        if (sec_tick && (sec_cnt_r == CD_LAST)) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_COOLDOWN;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register, cooldown seconds counter and saturating press counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      sec_cnt_r     <= 5'd0;
      press_count_r <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r != ST_COOLDOWN) begin
        sec_cnt_r <= 5'd0;
      end else if (sec_tick) begin
        sec_cnt_r <= sec_cnt_r + 5'd1;
      end else begin
        sec_cnt_r <= sec_cnt_r;
      end
      if (count_en_s && (press_count_r != 8'd255)) begin
        press_count_r <= press_count_r + 8'd1;
      end else begin
        press_count_r <= press_count_r;
      end
    end
  end

  assign fsm_state   = state_r;
  assign press_count = press_count_r;

`ifdef PED_REQ_BLINK_EN
  logic blink_r;

  // Blink phase: set on PENDING entry, toggled by each second tick while pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_r <= 1'b0;
    end else if ((state_r != ST_PENDING) && (state_nxt_s == ST_PENDING)) begin
      blink_r <= 1'b1;
    end else if ((state_r == ST_PENDING) && sec_tick) begin
      blink_r <= ~blink_r;
    end else begin
      blink_r <= blink_r;
    end
  end

  assign wait_led = ((state_r == ST_PENDING) && blink_r) || (state_r == ST_GRANTED);
`else
  assign wait_led = (state_r == ST_PENDING) || (state_r == ST_GRANTED);
`endif

endmodule

// File: tb/tb_ped_request_ctrl.sv
// Directed self-checking bench for ped_request_ctrl (DEBOUNCE_CYCLES=4, COOLDOWN_S=3).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_ped_request_ctrl;

  logic       clk;
  logic       reset;
  logic       btn_n;
  logic [1:0] light_state;
  logic       sec_tick;
  logic       req_ack;
  logic       req_valid;
  logic       wait_led;
  logic [1:0] fsm_state;
  logic [7:0] press_count;

  int checks;
  int errors;

  ped_request_ctrl #(.DEBOUNCE_CYCLES(4), .COOLDOWN_S(3)) dut (
    .clk(clk), .reset(reset), .btn_n(btn_n), .light_state(light_state),
    .sec_tick(sec_tick), .req_ack(req_ack), .req_valid(req_valid),
    .wait_led(wait_led), .fsm_state(fsm_state), .press_count(press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Full press: 8 cycles low (event fires after 7), 8 cycles high to re-arm.
  task automatic press();
    btn_n = 1'b0;
    cycles(8);
    btn_n = 1'b1;
    cycles(8);
  endtask

  task automatic tick();
    sec_tick = 1'b1;
    cycles(1);
    sec_tick = 1'b0;
    cycles(1);
  endtask

  // Bounded wait for a state; an expired budget counts as a failed check.
  task automatic wait_state(input logic [1:0] exp, input int budget, input string name);
    int n;
    n = 0;
    while ((fsm_state !== exp) && (n < budget)) begin
      cycles(1);
      n++;
    end
    checks++;
    if (fsm_state !== exp) begin
      errors++;
      $display("FAIL %s timeout: fsm_state got %b expected %b", name, fsm_state, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    cycles(1);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (fsm_state !== 2'b00) begin errors++; $display("FAIL reset_state got %b expected 00", fsm_state); end
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %b expected 0", req_valid); end
    checks++; if (wait_led !== 1'b0) begin errors++; $display("FAIL reset_wait_led got %b expected 0", wait_led); end
    checks++; if (press_count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d expected 0", press_count); end
  endtask

  task automatic test_bounce();
    btn_n = 1'b0;
    cycles(3);
    btn_n = 1'b1;
    cycles(12);
    checks++; if (fsm_state !== 2'b00) begin errors++; $display("FAIL bounce_state got %b expected 00", fsm_state); end
    checks++; if (press_count !== 8'd0) begin errors++; $display("FAIL bounce_count got %0d expected 0", press_count); end
  endtask

  task automatic test_handshake();
    light_state = 2'b00;
    btn_n = 1'b0;
    cycles(10);
    btn_n = 1'b1;
    cycles(8);
    checks++; if (fsm_state !== 2'b01) begin errors++; $display("FAIL hs_pending got %b expected 01", fsm_state); end
    checks++; if (wait_led !== 1'b1) begin errors++; $display("FAIL hs_wait_led got %b expected 1", wait_led); end
    checks++; if (press_count !== 8'd1) begin errors++; $display("FAIL hs_count got %0d expected 1", press_count); end
    cycles(2);
    checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL hs_req_valid got %b expected 1", req_valid); end
    req_ack = 1'b1;
    cycles(1);
    req_ack = 1'b0;
    checks++; if (fsm_state !== 2'b10) begin errors++; $display("FAIL hs_granted got %b expected 10", fsm_state); end
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL hs_valid_after_ack got %b expected 0", req_valid); end
    // ack outside PENDING must have no effect
    req_ack = 1'b1;
    cycles(1);
    req_ack = 1'b0;
    checks++; if (fsm_state !== 2'b10) begin errors++; $display("FAIL hs_ack_ignored got %b expected 10", fsm_state); end
    light_state = 2'b10;
    cycles(1);
    checks++; if (fsm_state !== 2'b11) begin errors++; $display("FAIL hs_cooldown got %b expected 11", fsm_state); end
    checks++; if (wait_led !== 1'b0) begin errors++; $display("FAIL hs_cd_wait_led got %b expected 0", wait_led); end
    tick();
    tick();
    press();
    checks++; if (press_count !== 8'd1) begin errors++; $display("FAIL cd_press_ignored got %0d expected 1", press_count); end
    checks++; if (fsm_state !== 2'b11) begin errors++; $display("FAIL cd_hold got %b expected 11", fsm_state); end
    tick();
    checks++; if (fsm_state !== 2'b00) begin errors++; $display("FAIL cd_exit got %b expected 00", fsm_state); end
  endtask

  task automatic test_serve_red();
    light_state = 2'b10;
    btn_n = 1'b0;
    wait_state(2'b01, 20, "red_pending");
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL red_no_valid got %b expected 0", req_valid); end
    cycles(1);
    checks++; if (fsm_state !== 2'b11) begin errors++; $display("FAIL red_cooldown got %b expected 11", fsm_state); end
    btn_n = 1'b1;
    cycles(8);
    checks++; if (press_count !== 8'd2) begin errors++; $display("FAIL red_count got %0d expected 2", press_count); end
    tick();
    tick();
    // press event lands on the same cycle as the final tick
    btn_n = 1'b0;
    cycles(6);
    sec_tick = 1'b1;
    cycles(1);
    sec_tick = 1'b0;
    checks++; if (fsm_state !== 2'b00) begin errors++; $display("FAIL final_tick_exit got %b expected 00", fsm_state); end
    btn_n = 1'b1;
    cycles(10);
    checks++; if (fsm_state !== 2'b00) begin errors++; $display("FAIL final_tick_press_state got %b expected 00", fsm_state); end
    checks++; if (press_count !== 8'd2) begin errors++; $display("FAIL final_tick_press_count got %0d expected 2", press_count); end
  endtask

  task automatic test_light_leave();
    light_state = 2'b00;
    press();
    checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL leave_valid_green got %b expected 1", req_valid); end
    light_state = 2'b01;
    cycles(1);
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL leave_valid_yellow got %b expected 0", req_valid); end
    checks++; if (fsm_state !== 2'b01) begin errors++; $display("FAIL leave_state got %b expected 01", fsm_state); end
    // illegal light state behaves like yellow: no handshake, no serve
    light_state = 2'b11;
    req_ack = 1'b1;
    cycles(1);
    req_ack = 1'b0;
    cycles(1);
    checks++; if (fsm_state !== 2'b01) begin errors++; $display("FAIL illegal_light got %b expected 01", fsm_state); end
    press();
    checks++; if (press_count !== 8'd4) begin errors++; $display("FAIL merge_count got %0d expected 4", press_count); end
    checks++; if (fsm_state !== 2'b01) begin errors++; $display("FAIL merge_state got %b expected 01", fsm_state); end
    light_state = 2'b00;
    cycles(1);
    checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL return_green_valid got %b expected 1", req_valid); end
  endtask

  task automatic test_reset_granted();
    do_reset();
    light_state = 2'b00;
    press();
    req_ack = 1'b1;
    cycles(1);
    req_ack = 1'b0;
    for (int i = 0; i < 4; i++) press();
    checks++; if (press_count !== 8'd5) begin errors++; $display("FAIL grant_count got %0d expected 5", press_count); end
    checks++; if (fsm_state !== 2'b10) begin errors++; $display("FAIL grant_state got %b expected 10", fsm_state); end
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    checks++; if ({fsm_state, req_valid, wait_led} !== 4'b0000) begin errors++; $display("FAIL midreset_outputs got %b expected 0000", {fsm_state, req_valid, wait_led}); end
    checks++; if (press_count !== 8'd0) begin errors++; $display("FAIL midreset_count got %0d expected 0", press_count); end
    press();
    checks++; if (press_count !== 8'd1) begin errors++; $display("FAIL after_reset_count got %0d expected 1", press_count); end
    checks++; if (fsm_state !== 2'b01) begin errors++; $display("FAIL after_reset_state got %b expected 01", fsm_state); end
  endtask

  task automatic test_saturation();
    req_ack = 1'b1;
    cycles(1);
    req_ack = 1'b0;
    for (int i = 0; i < 258; i++) press();
    checks++; if (press_count !== 8'd255) begin errors++; $display("FAIL saturate_count got %0d expected 255", press_count); end
    checks++; if (fsm_state !== 2'b10) begin errors++; $display("FAIL saturate_state got %b expected 10", fsm_state); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    btn_n = 1'b1;
    light_state = 2'b00;
    sec_tick = 1'b0;
    req_ack = 1'b0;
    test_reset();
    test_bounce();
    test_handshake();
    test_serve_red();
    test_light_leave();
    test_reset_granted();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
